rv32_instr_decoder: RTL and testbench
=====================================

Name: rv32_instr_decoder

Overview:
- Registered RV32I base-instruction field decoder: splits a 32-bit instruction word into opcode, funct fields, register indices, format class and a sign-extended immediate.
- Used by the retirement-trace (RVFI) monitor beside the 2-stage core to recover rs1/rs2/rd and the immediate of each retired instruction.
- Fields a format does not use are forced to zero, so downstream register-file lookups through x0 read 0.

Parameters:
- none

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- valid_i  input  1  instr_i is valid this cycle
- instr_i  input  32  instruction word
- valid_o  output  1  registered valid_i
- format_o  output  3  format class: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=INVALID (6 is never driven)
- op_o  output  7  instr[6:0]
- funct_3_o  output  3  funct3, or 0 if unused
- funct_7_o  output  7  funct7, or 0 if unused
- rd_o  output  5  destination register, or 0 if unused
- rs1_o  output  5  source 1, or 0 if unused
- rs2_o  output  5  source 2, or 0 if unused
- imm_o  output  32  sign-extended immediate, or 0 if unused

Behaviour:
- Latency is 1 cycle. On each rising edge with reset=0, every output register loads the decode of the current instr_i, and valid_o loads valid_i.
- Decode is performed regardless of valid_i. Consumers qualify the outputs with valid_o.
- Reset, synchronous, takes priority over everything. On reset: valid_o=0, format_o=7, all other outputs=0.
- Reset asserted mid-stream discards the in-flight decode. The first post-reset decode appears 1 cycle after reset deasserts.
- Opcode-to-format mapping (instr[6:0]):
  - 0110011 -> R
  - 0010011, 0000011, 1100111, 0001111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - any other value -> INVALID
- op_o = instr[6:0] always, including for INVALID.
- Field rules:
  - R: rd, rs1, rs2, funct3, funct7 all taken from the instruction; imm=0.
  - I: rd, rs1, funct3 taken from the instruction; rs2=0.
    - funct7 = instr[31:25] only for opcode 0010011 with funct3 001 or 101 (shifts); otherwise 0.
  - S, B: rs1, rs2, funct3 taken from the instruction; rd=0, funct7=0.
  - U, J: rd taken from the instruction; rs1=rs2=funct3=funct7=0.
  - INVALID: rd, rs1, rs2, funct3, funct7 and imm are all 0.
- Immediate construction (sign bit is always instr[31]):
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: {instr[31:12], 12'b0}
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
- Shift-immediate instructions keep the full I-immediate; imm_o is not masked to the shamt bits.
- No funct3/funct7 legality checking in the base build. Undefined funct combinations decode structurally by opcode.

Optional Feature:
- Macro: DECODER_ILLEGAL_CHECK_EN.
- When defined:
  - Adds output illegal_o (1 bit), registered alongside the other outputs; reset value 0.
  - illegal_o=1 when any of the following holds:
    - format is INVALID;
    - an R-type funct7 is not 0000000, or not 0100000 for funct3 000/101;
    - a shift-immediate funct7 is not 0000000, or not 0100000 for funct3 101;
    - a load funct3 is in {011, 110, 111};
    - a store funct3 is greater than 010;
    - a branch funct3 is 010 or 011;
    - JALR funct3 is not 000.
  - All other outputs are unchanged by this feature.
- When not defined: the illegal_o port does not exist.

Test Plan:
- Reset held 2 cycles -> valid_o=0, format_o=7, all other outputs 0. Release reset and drive valid_i=1 with 0x002081B3 (add) -> next cycle valid_o=1, format 0, op 0x33, rd 3, rs1 1, rs2 2, f3 0, f7 0x00, imm 0. Then 0x402081B3 -> f7 0x20.
- 0xFFF10093 (addi x1,x2,-1) -> format 1, rd 1, rs1 2, rs2 0, f3 0, f7 0, imm 0xFFFFFFFF.
- 0x00512423 (sw x5,8(x2)) -> format 2, rd 0, rs1 2, rs2 5, f3 2, imm 0x00000008.
- 0xFE208EE3 (beq x1,x2,-4) -> format 3, rs1 1, rs2 2, rd 0, imm 0xFFFFFFFC.
- 0x123451B7 (lui x3,0x12345) -> format 4, rd 3, rs1 0, rs2 0, imm 0x12345000. 0x001000EF (jal x1,+2048) -> format 5, rd 1, imm 0x00000800.
- 0x0000007F -> format 7, op 0x7F, all other fields 0; with DECODER_ILLEGAL_CHECK_EN, illegal_o=1. Assert reset in the same cycle as a valid instruction -> outputs return to reset values the next cycle.

Source files
------------

// File: rtl/rv32_instr_decoder.sv
// rv32_instr_decoder: registered RV32I field/immediate decoder; define DECODER_ILLEGAL_CHECK_EN to add illegal_o
module rv32_instr_decoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [2:0]  format_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct_3_o,
    output logic [6:0]  funct_7_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o
`ifdef DECODER_ILLEGAL_CHECK_EN
    ,
    output logic        illegal_o
`endif
);
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_X = 3'd7;
    logic [6:0]  op, f7;
    logic [2:0]  f3, fmt_d;
    logic        shift_imm;
    logic [2:0]  f3_d;
    logic [6:0]  f7_d;
    logic [4:0]  rd_d, rs1_d, rs2_d;
    logic [31:0] imm_d;
    logic        valid_q;
    logic [2:0]  fmt_q, f3_q;
    logic [6:0]  op_q, f7_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [31:0] imm_q;
    assign op = instr_i[6:0];
    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];
    always_comb begin
        fmt_d = F_X;
        case (op)
            7'b0110011: fmt_d = F_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: fmt_d = F_I;
            7'b0100011: fmt_d = F_S;
            7'b1100011: fmt_d = F_B;
            7'b0110111, 7'b0010111: fmt_d = F_U;
            7'b1101111: fmt_d = F_J;
            default: fmt_d = F_X;
        endcase
    end
    // slli/srli/srai carry funct7 in the upper immediate bits
    assign shift_imm = op == 7'b0010011 && f3[1:0] == 2'b01;
    assign rd_d  = fmt_d inside {F_R, F_I, F_U, F_J} ? instr_i[11:7] : '0;
    assign rs1_d = fmt_d inside {F_R, F_I, F_S, F_B} ? instr_i[19:15] : '0;
    assign rs2_d = fmt_d inside {F_R, F_S, F_B} ? instr_i[24:20] : '0;
    assign f3_d  = fmt_d inside {F_R, F_I, F_S, F_B} ? f3 : '0;
    assign f7_d  = fmt_d == F_R || shift_imm ? f7 : '0;
    assign imm_d = fmt_d == F_I ? {{20{instr_i[31]}}, instr_i[31:20]} :
                   fmt_d == F_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                   fmt_d == F_B ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                   fmt_d == F_U ? {instr_i[31:12], 12'b0} :
                   fmt_d == F_J ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                   '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            fmt_q   <= F_X;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_i;
            fmt_q   <= fmt_d;
            op_q    <= op;
            f3_q    <= f3_d;
            f7_q    <= f7_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
        end
    end
    assign valid_o   = valid_q;
    assign format_o  = fmt_q;
    assign op_o      = op_q;
    assign funct_3_o = f3_q;
    assign funct_7_o = f7_q;
    assign rd_o      = rd_q;
    assign rs1_o     = rs1_q;
    assign rs2_o     = rs2_q;
    assign imm_o     = imm_q;
`ifdef DECODER_ILLEGAL_CHECK_EN
    logic illegal_d, illegal_q;
    assign illegal_d = fmt_d == F_X ||
                       (fmt_d == F_R && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ||
                       (shift_imm && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5))) ||
                       (op == 7'b0000011 && f3 inside {3'd3, 3'd6, 3'd7}) ||
                       (op == 7'b0100011 && f3 > 3'd2) ||
                       (op == 7'b1100011 && f3 inside {3'd2, 3'd3}) ||
                       (op == 7'b1100111 && f3 != 3'd0);
    always_ff @(posedge clock) begin
        if (reset) illegal_q <= 1'b0;
        else illegal_q <= illegal_d;
    end
    assign illegal_o = illegal_q;
`endif
endmodule

// File: tb/tb_rv32_instr_decoder.sv
// tb_rv32_instr_decoder: directed and randomized checks of rv32_instr_decoder against a behavioural model
module tb_rv32_instr_decoder;
    typedef struct packed {
        logic        valid;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } out_t;

    localparam logic [6:0] OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic        valid_o;
    logic [2:0]  format_o;
    logic [6:0]  op_o;
    logic [2:0]  funct_3_o;
    logic [6:0]  funct_7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [31:0] imm_o;
    logic        illegal;
    int          checks = 0;
    int          errors = 0;

`ifdef DECODER_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
    assign illegal = 1'b0;
`endif

    rv32_instr_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .valid_i   (valid_i),
        .instr_i   (instr_i),
        .valid_o   (valid_o),
        .format_o  (format_o),
        .op_o      (op_o),
        .funct_3_o (funct_3_o),
        .funct_7_o (funct_7_o),
        .rd_o      (rd_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .imm_o     (imm_o)
`ifdef DECODER_ILLEGAL_CHECK_EN
        ,
        .illegal_o (illegal)
`endif
    );

    always #5 clock = ~clock;

    function automatic out_t observed();
        return {valid_o, format_o, op_o, funct_3_o, funct_7_o, rd_o, rs1_o, rs2_o, imm_o, illegal};
    endfunction

    function automatic out_t reset_value();
        out_t e = '0;
        e.fmt = 3'd7;
        return e;
    endfunction

    // Expected decode built from the field and immediate rules using weighted-bit arithmetic
    function automatic out_t model(input logic v, input logic [31:0] i);
        out_t e = '0;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int sgn;
        bit shift;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        sgn = i[31] ? 1 : 0;
        e.valid = v;
        e.op = op;
        if (op == 7'h33) e.fmt = 3'd0;
        else if (op inside {7'h13, 7'h03, 7'h67, 7'h0F, 7'h73}) e.fmt = 3'd1;
        else if (op == 7'h23) e.fmt = 3'd2;
        else if (op == 7'h63) e.fmt = 3'd3;
        else if (op inside {7'h37, 7'h17}) e.fmt = 3'd4;
        else if (op == 7'h6F) e.fmt = 3'd5;
        else e.fmt = 3'd7;
        shift = op == 7'h13 && f3 inside {3'd1, 3'd5};
        if (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) e.rd = i[11:7];
        if (e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) begin
            e.rs1 = i[19:15];
            e.f3 = f3;
        end
        if (e.fmt inside {3'd0, 3'd2, 3'd3}) e.rs2 = i[24:20];
        if (e.fmt == 3'd0 || shift) e.f7 = f7;
        case (e.fmt)
            3'd1: e.imm = 32'(int'(i[30:20]) - sgn * 2048);
            3'd2: e.imm = 32'(int'(f7[5:0]) * 32 + int'(i[11:7]) - sgn * 2048);
            3'd3: e.imm = 32'(int'(i[7]) * 2048 + int'(f7[5:0]) * 32 + int'(i[11:8]) * 2 - sgn * 4096);
            3'd4: e.imm = 32'(i[31:12]) * 32'd4096;
            3'd5: e.imm = 32'(int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - sgn * (1 << 20));
            default: e.imm = '0;
        endcase
        e.ill = ILL_EN && (e.fmt == 3'd7 ||
                (e.fmt == 3'd0 && !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}))) ||
                (shift && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5))) ||
                (op == 7'h03 && f3 inside {3'd3, 3'd6, 3'd7}) ||
                (op == 7'h23 && f3 > 3'd2) ||
                (op == 7'h63 && f3 inside {3'd2, 3'd3}) ||
                (op == 7'h67 && f3 != 3'd0));
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        if (k < 11) w[6:0] = OPS[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        out_t o;
        valid_i = 1'b1;
        instr_i = 32'h002081B3;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock);
            #1;
            o = observed();
            checks++;
            if (o !== reset_value()) begin
                errors++;
                $display("FAIL reset_cycle%0d got %h exp %h", c, o, reset_value());
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_in [8];
        out_t        d_exp [8];
        out_t        o, e;
        d_in[0] = 32'h002081B3; d_exp[0] = '{1'b1, 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0};
        d_in[1] = 32'h402081B3; d_exp[1] = '{1'b1, 3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0};
        d_in[2] = 32'hFFF10093; d_exp[2] = '{1'b1, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0};
        d_in[3] = 32'h00512423; d_exp[3] = '{1'b1, 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd5, 32'h00000008, 1'b0};
        d_in[4] = 32'hFE208EE3; d_exp[4] = '{1'b1, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0};
        d_in[5] = 32'h123451B7; d_exp[5] = '{1'b1, 3'd4, 7'h37, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0};
        d_in[6] = 32'h001000EF; d_exp[6] = '{1'b1, 3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0};
        d_in[7] = 32'h0000007F; d_exp[7] = '{1'b1, 3'd7, 7'h7F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000000, ILL_EN};
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            reset = 1'b0;
            valid_i = 1'b1;
            instr_i = d_in[n];
            @(posedge clock);
            #1;
            o = observed();
            e = d_exp[n];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL directed_%08h got %h exp %h", d_in[n], o, e);
            end
        end
    endtask

    task automatic test_random();
        out_t o, e;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            valid_i = 1'($urandom_range(0, 1));
            instr_i = rand_instr();
            e = model(valid_i, instr_i);
            @(posedge clock);
            #1;
            o = observed();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_%08h got %h exp %h", instr_i, o, e);
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_t o, e;
        @(negedge clock);
        valid_i = 1'b1;
        instr_i = 32'hFFF10093;
        e = model(1'b1, instr_i);
        @(posedge clock);
        #1;
        o = observed();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL pre_reset got %h exp %h", o, e);
        end
        @(negedge clock);
        reset = 1'b1;
        instr_i = 32'h001000EF;
        @(posedge clock);
        #1;
        o = observed();
        checks++;
        if (o !== reset_value()) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", o, reset_value());
        end
        @(negedge clock);
        reset = 1'b0;
        instr_i = 32'hFE208EE3;
        e = model(1'b1, instr_i);
        @(posedge clock);
        #1;
        o = observed();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL post_reset got %h exp %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
